// File: rtl/clk_ctrl_pkg.sv
// Shared types and defaults for the PLL power-up sequencer.
// State encoding, counter width and the registered output decode.
package clk_ctrl_pkg;

    localparam int CNT_W = 16;

    localparam int DEF_PLL_RST_CYC = 100;
    localparam int DEF_LOCK_FILT   = 8;
    localparam int DEF_LOCK_TMO    = 65535;
    localparam int DEF_DIV_RST_CYC = 16;
    localparam int DEF_MAX_RETRY   = 3;

    typedef enum logic [2:0] {
        ST_PRST  = 3'd0,
        ST_WLOCK = 3'd1,
        ST_DRST  = 3'd2,
        ST_RUN   = 3'd3,
        ST_FAULT = 3'd4
    } state_e;

    typedef struct packed {
        logic pll_rst;
        logic div_rst;
        logic sys_rst;
        logic ready;
        logic fault;
    } seq_out_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    function automatic seq_out_t decode_state(input state_e s);
        seq_out_t o;
        o.pll_rst = 1'b1;
        o.div_rst = 1'b1;
        o.sys_rst = 1'b1;
        o.ready   = 1'b0;
        o.fault   = 1'b0;
        unique case (s)
            ST_WLOCK,
            ST_DRST: o.pll_rst = 1'b0;
            ST_RUN: begin
                o.pll_rst = 1'b0;
                o.div_rst = 1'b0;
                o.sys_rst = 1'b0;
                o.ready   = 1'b1;
            end
            ST_FAULT: o.fault = 1'b1;
            default: ;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/lock_filter.sv
// Consecutive-high filter on the combined PLL lock.
// accepted_o rises once the registered count has reached LOCK_FILT.
module lock_filter
    import clk_ctrl_pkg::*;
#(
    parameter int LOCK_FILT = DEF_LOCK_FILT
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic lock_i,
    output logic accepted_o
);

    localparam logic [CNT_W-1:0] FILT_END = CNT_W'(LOCK_FILT);

    logic [CNT_W-1:0] filt_q;
    logic [CNT_W-1:0] filt_d;

    always_comb begin
        filt_d = '0;
        if (en_i && lock_i) begin
            filt_d = (filt_q >= FILT_END) ? FILT_END : sat_inc(filt_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            filt_q <= '0;
        end else begin
            filt_q <= filt_d;
        end
    end

    assign accepted_o = (filt_q == FILT_END);

endmodule

// File: rtl/pll_seq_ctrl.sv
// PLL reset / lock / divider-reset sequencer with retry and fault hold.
// Define PLL_SEQ_STATUS_EN to expose lol_cnt and state_o.
module pll_seq_ctrl
    import clk_ctrl_pkg::*;
#(
    parameter int PLL_RST_CYC = DEF_PLL_RST_CYC,
    parameter int LOCK_FILT   = DEF_LOCK_FILT,
    parameter int LOCK_TMO    = DEF_LOCK_TMO,
    parameter int DIV_RST_CYC = DEF_DIV_RST_CYC,
    parameter int MAX_RETRY   = DEF_MAX_RETRY
) (
    input  logic clk,
    input  logic rst,
    input  logic lock_l,
    input  logic lock_h,
    input  logic soft_req,
    output logic pll_rst,
    output logic div_rst,
    output logic sys_rst,
    output logic ready,
    output logic fault
`ifdef PLL_SEQ_STATUS_EN
    ,
    output logic [7:0] lol_cnt,
    output logic [2:0] state_o
`endif
);

    localparam logic [CNT_W-1:0] PRST_END = CNT_W'(PLL_RST_CYC - 1);
    localparam logic [CNT_W-1:0] TMO_END  = CNT_W'(LOCK_TMO - 1);
    localparam logic [CNT_W-1:0] DRST_END = CNT_W'(DIV_RST_CYC - 1);
    localparam logic [3:0]       RETRY_LIM = 4'(MAX_RETRY);

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [3:0]       retry_q;
    logic [3:0]       retry_d;
    seq_out_t         out_q;
    logic             lock_ok;
    logic             accepted;

    assign lock_ok = lock_l & lock_h;

    lock_filter #(
        .LOCK_FILT (LOCK_FILT)
    ) u_filt (
        .clk        (clk),
        .rst        (rst),
        .en_i       ((state_q == ST_WLOCK) && !soft_req),
        .lock_i     (lock_ok),
        .accepted_o (accepted)
    );

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        if (soft_req) begin
            state_d = ST_PRST;
            retry_d = '0;
        end else begin
            unique case (state_q)
                ST_PRST: begin
                    if (cnt_q >= PRST_END) state_d = ST_WLOCK;
                end
                ST_WLOCK: begin
                    // acceptance beats a coincident timeout
                    if (accepted) begin
                        state_d = ST_DRST;
                    end else if (cnt_q >= TMO_END) begin
                        retry_d = retry_q + 4'd1;
                        state_d = (retry_d >= RETRY_LIM) ? ST_FAULT : ST_PRST;
                    end
                end
                ST_DRST: begin
                    if (!lock_ok) begin
                        state_d = ST_PRST;
                    end else if (cnt_q >= DRST_END) begin
                        state_d = ST_RUN;
                        retry_d = '0;
                    end
                end
                ST_RUN: begin
                    if (!lock_ok) state_d = ST_PRST;
                end
                ST_FAULT: ;
                default: state_d = ST_PRST;
            endcase
        end
        cnt_d = (soft_req || (state_d != state_q)) ? '0 : sat_inc(cnt_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_PRST;
            cnt_q   <= '0;
            retry_q <= '0;
            out_q   <= decode_state(ST_PRST);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            retry_q <= retry_d;
            out_q   <= decode_state(state_q);
        end
    end

    assign pll_rst = out_q.pll_rst;
    assign div_rst = out_q.div_rst;
    assign sys_rst = out_q.sys_rst;
    assign ready   = out_q.ready;
    assign fault   = out_q.fault;

`ifdef PLL_SEQ_STATUS_EN
    logic [7:0] lol_q;
    logic [7:0] lol_d;

    always_comb begin
        lol_d = lol_q;
        if ((state_q == ST_RUN) && !lock_ok && !soft_req && (lol_q != 8'hFF)) begin
            lol_d = lol_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lol_q <= '0;
        end else begin
            lol_q <= lol_d;
        end
    end

    assign lol_cnt = lol_q;
    assign state_o = state_q;
`endif

endmodule

// File: tb/tb_pll_seq_ctrl.sv
// Scoreboard bench for pll_seq_ctrl: expected output changes and their
// cycle stamps are queued by the stimulus and matched by a monitor.
`timescale 1ns/1ps
module tb_pll_seq_ctrl;

    typedef struct {
        int         c;
        logic [4:0] v;
    } exp_t;

    localparam logic [4:0] V_P = 5'b11100;
    localparam logic [4:0] V_W = 5'b01100;
    localparam logic [4:0] V_R = 5'b00010;
    localparam logic [4:0] V_F = 5'b11101;

    logic clk = 1'b0;
    logic rst;
    logic lock_l;
    logic lock_h;
    logic soft_req;
    logic pll_rst;
    logic div_rst;
    logic sys_rst;
    logic ready;
    logic fault;
`ifdef PLL_SEQ_STATUS_EN
    logic [7:0] lol_cnt;
    logic [2:0] state_o;
`endif

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;
    exp_t q[$];

    pll_seq_ctrl #(
        .PLL_RST_CYC (100),
        .LOCK_FILT   (8),
        .LOCK_TMO    (50),
        .DIV_RST_CYC (16),
        .MAX_RETRY   (3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .lock_l   (lock_l),
        .lock_h   (lock_h),
        .soft_req (soft_req),
        .pll_rst  (pll_rst),
        .div_rst  (div_rst),
        .sys_rst  (sys_rst),
        .ready    (ready),
        .fault    (fault)
`ifdef PLL_SEQ_STATUS_EN
        ,
        .lol_cnt  (lol_cnt),
        .state_o  (state_o)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input int c, input logic [4:0] v);
        exp_t e;
        e.c = c;
        e.v = v;
        q.push_back(e);
    endtask

    task automatic step_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // monitor: every change of the output vector consumes one expectation
    initial begin
        logic [4:0] last;
        logic [4:0] cur;
        exp_t       e;
        last = V_P;
        forever begin
            @(negedge clk);
            cur = {pll_rst, div_rst, sys_rst, ready, fault};
            if (mon_en && (cur !== last)) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_change cyc=%0d got=%b", cyc, cur);
                end else begin
                    e = q.pop_front();
                    if ((cur !== e.v) || (cyc != e.c)) begin
                        errors++;
                        $display("FAIL out_change cyc=%0d got=%b exp=%b at cyc=%0d",
                                 cyc, cur, e.v, e.c);
                    end
                end
                last = cur;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d pending=%0d", cyc, q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        rst      = 1'b1;
        lock_l   = 1'b1;
        lock_h   = 1'b1;
        soft_req = 1'b0;
        repeat (3) @(negedge clk);

        checks++;
        if ({pll_rst, div_rst, sys_rst, ready, fault} !== V_P) begin
            errors++;
            $display("FAIL reset_outputs got=%b exp=%b",
                     {pll_rst, div_rst, sys_rst, ready, fault}, V_P);
        end
        mon_en = 1'b1;

        // power-up with locks high: ready 126 edges after release
        b = cyc;
        push(b + 101, V_W);
        push(b + 126, V_R);
        rst = 1'b0;
        step_to(b + 130);

        // single-cycle lock_l drop in RUN
        b = cyc;
        lock_l = 1'b0;
        push(b + 2, V_P);
        push(b + 102, V_W);
        push(b + 127, V_R);
        @(negedge clk);
        lock_l = 1'b1;
        step_to(b + 130);
`ifdef PLL_SEQ_STATUS_EN
        checks++;
        if (lol_cnt !== 8'd1) begin
            errors++;
            $display("FAIL lol_cnt got=%0d exp=1", lol_cnt);
        end
`endif

        // soft_req from RUN, then soft_req on the acceptance edge
        b = cyc;
        soft_req = 1'b1;
        push(b + 2, V_P);
        push(b + 102, V_W);
        push(b + 111, V_P);
        push(b + 211, V_W);
        @(negedge clk);
        soft_req = 1'b0;
        step_to(b + 109);
        soft_req = 1'b1;
        @(negedge clk);
        soft_req = 1'b0;

        // rst pulse while in DRST
        step_to(b + 225);
        rst = 1'b1;
        push(b + 226, V_P);
        push(b + 327, V_W);
        push(b + 352, V_R);
        @(negedge clk);
        rst = 1'b0;
        step_to(b + 355);

        // chattering lock_h times out, then locks low until FAULT
        b = cyc;
        push(b + 2, V_P);
        push(b + 102, V_W);
        push(b + 152, V_P);
        push(b + 252, V_W);
        push(b + 302, V_P);
        push(b + 402, V_W);
        push(b + 452, V_F);
        for (int i = 0; i < 152; i++) begin
            soft_req = (i == 0);
            lock_l   = 1'b1;
            lock_h   = ((i / 5) % 2) == 0;
            @(negedge clk);
        end
        lock_l = 1'b0;
        lock_h = 1'b0;
        step_to(b + 480);

        // soft_req leaves FAULT and the sequence completes
        b = cyc;
        soft_req = 1'b1;
        lock_l   = 1'b1;
        lock_h   = 1'b1;
        push(b + 2, V_P);
        push(b + 102, V_W);
        push(b + 127, V_R);
        @(negedge clk);
        soft_req = 1'b0;
        step_to(b + 135);

        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL pending_expect got=%0d exp=0 next_cyc=%0d",
                     q.size(), q[0].c);
        end
`ifdef PLL_SEQ_STATUS_EN
        checks++;
        if (lol_cnt !== 8'd1) begin
            errors++;
            $display("FAIL lol_cnt_final got=%0d exp=1", lol_cnt);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
